// File: rtl/breath_duty_if.sv
// rtl/breath_duty_if.sv - key input and duty/mode status bundle of the breathing duty generator
interface breath_duty_if;
    logic       key_in;
    logic [7:0] duty;
    logic       duty_valid;
    logic       dir;
    logic [1:0] mode;
    logic       key_press;

    modport master (
        input  key_in,
        output duty,
        output duty_valid,
        output dir,
        output mode,
        output key_press
    );

    modport slave (
        output key_in,
        input  duty,
        input  duty_valid,
        input  dir,
        input  mode,
        input  key_press
    );
endinterface

// File: rtl/breath_duty_gen.sv
// rtl/breath_duty_gen.sv - debounced mode key plus triangular duty ramp for the PWM LED driver
module breath_duty_gen #(
    parameter int CNT_DEB   = 1_000_000,
    parameter int STEP_BASE = 50_000,
    parameter int DUTY_MAX  = 255
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    breath_duty_if.master bus
);

    localparam int DW = $clog2(CNT_DEB + 1);
    localparam int SW = $clog2(STEP_BASE * 4 + 1);
    localparam logic [7:0] DMAX = 8'(DUTY_MAX);

    typedef enum logic [1:0] {RISE, FALL, HOLD} ramp_state_t;

    logic          key_s1, key_s2, key_deb, key_deb_q;
    logic [DW-1:0] deb_cnt;
    logic          key_press_r;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_s1      <= 1'b1;
            key_s2      <= 1'b1;
            key_deb     <= 1'b1;
            key_deb_q   <= 1'b1;
            deb_cnt     <= '0;
            key_press_r <= 1'b0;
        end else begin
            key_s1      <= bus.key_in;
            key_s2      <= key_s1;
            key_deb_q   <= key_deb;
            key_press_r <= key_deb_q & ~key_deb;
            if (key_s2 == key_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(CNT_DEB - 1)) begin
                key_deb <= key_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    logic [1:0]    mode_r;
    logic [SW-1:0] step_cnt;
    logic [SW-1:0] interval;
    logic          tick;
    logic          step;

    assign interval = SW'(STEP_BASE) << mode_r;
    assign tick     = (mode_r != 2'd3) && (step_cnt == interval - 1'b1);
    // A press restarts the interval, so a coincident tick is dropped.
    assign step     = tick && !key_press_r;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_r   <= 2'd0;
            step_cnt <= '0;
        end else if (key_press_r) begin
            mode_r   <= mode_r + 1'b1;
            step_cnt <= '0;
        end else if (mode_r == 2'd3 || tick) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    ramp_state_t state, state_n;
    logic [7:0]  duty_r, duty_n;
    logic        dir_r, dir_n;
    logic        valid_r, valid_n;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= RISE;
            duty_r  <= 8'd0;
            dir_r   <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state   <= state_n;
            duty_r  <= duty_n;
            dir_r   <= dir_n;
            valid_r <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        duty_n  = duty_r;
        dir_n   = dir_r;
        valid_n = 1'b0;
        case (state)
            RISE: begin
                if (mode_r == 2'd3) begin
                    state_n = HOLD;
                end else if (step) begin
                    duty_n  = duty_r + 8'd1;
                    valid_n = 1'b1;
                    if (duty_n == DMAX) begin
                        state_n = FALL;
                        dir_n   = 1'b0;
                    end
                end
            end
            FALL: begin
                if (mode_r == 2'd3) begin
                    state_n = HOLD;
                end else if (step) begin
                    duty_n  = duty_r - 8'd1;
                    valid_n = 1'b1;
                    if (duty_n == 8'd0) begin
                        state_n = RISE;
                        dir_n   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (mode_r == 2'd0) begin
                    state_n = dir_r ? RISE : FALL;
                end
            end
            default: state_n = RISE;
        endcase
    end

    assign bus.duty       = duty_r;
    assign bus.duty_valid = valid_r;
    assign bus.dir        = dir_r;
    assign bus.mode       = mode_r;
    assign bus.key_press  = key_press_r;

endmodule

// File: tb/tb_breath_duty_gen.sv
// tb/tb_breath_duty_gen.sv - scoreboard bench for breath_duty_gen with a triangle-wave reference
module tb_breath_duty_gen;
    localparam int CNT_DEB   = 4;
    localparam int STEP_BASE = 3;
    localparam int DUTY_MAX  = 4;
    localparam int PERIOD    = 2 * DUTY_MAX;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc;
    int   checks   = 0;
    int   failures = 0;

    breath_duty_if bus();

    breath_duty_gen #(
        .CNT_DEB  (CNT_DEB),
        .STEP_BASE(STEP_BASE),
        .DUTY_MAX (DUTY_MAX)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus)
    );

    always #10 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int tri_val(input int p);
        int t;
        t = p % PERIOD;
        return (t <= DUTY_MAX) ? t : PERIOD - t;
    endfunction

    function automatic int tri_dir(input int p);
        return ((p % PERIOD) < DUTY_MAX) ? 1 : 0;
    endfunction

    // Reference: steps taken so far, current mode, and the cycle the current interval started.
    int press_q[$];
    int m_mode, m_pos, m_last, apply_at;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_mode   = 0;
            m_pos    = 0;
            m_last   = 0;
            apply_at = -1;
        end else begin
            if (apply_at == cyc) begin
                m_mode   = (m_mode + 1) % 4;
                m_last   = cyc;
                apply_at = -1;
            end
            check("mode", bus.mode, m_mode);
            if (bus.key_press) begin
                if (press_q.size() == 0) check("unexpected_press", 1, 0);
                else check("press_cycle", cyc, press_q.pop_front());
                apply_at = cyc + 1;
            end else if (press_q.size() > 0 && cyc > press_q[0]) begin
                check("missed_press", 0, 1);
                void'(press_q.pop_front());
            end
            if (m_mode == 3) begin
                check("hold_valid", bus.duty_valid, 0);
            end else if (bus.duty_valid) begin
                check("step_cycle", cyc, m_last + (STEP_BASE << m_mode));
                m_pos  = (m_pos + 1) % PERIOD;
                m_last = cyc;
            end else if (cyc > m_last + (STEP_BASE << m_mode)) begin
                check("missing_step", 0, 1);
                m_last = cyc;
            end
            check("duty", bus.duty, tri_val(m_pos));
            check("dir", bus.dir, tri_dir(m_pos));
        end
    end

    task automatic key_pulse(input int low_len, input int high_len);
        @(negedge clk);
        bus.key_in = 1'b0;
        if (low_len >= CNT_DEB) press_q.push_back(cyc + CNT_DEB + 3);
        repeat (low_len) @(negedge clk);
        bus.key_in = 1'b1;
        repeat (high_len) @(negedge clk);
    endtask

    initial begin
        bool_wait_ok: begin end
        rst_n      = 1'b1;
        bus.key_in = 1'b1;
        #5 rst_n = 1'b0;
        #20;
        check("rst_duty", bus.duty, 0);
        check("rst_dir", bus.dir, 1);
        check("rst_mode", bus.mode, 0);
        check("rst_valid", bus.duty_valid, 0);
        check("rst_press", bus.key_press, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Free-running ramp in mode 0.
        repeat (40) @(negedge clk);

        // Short glitches must be ignored, then one clean press.
        for (int i = 0; i < 5; i++) key_pulse(2, 2);
        key_pulse(10, 20);

        // Modes 2, 3 (100-cycle hold), then wrap to 0.
        key_pulse(10, 60);
        key_pulse(10, 100);
        key_pulse(10, 30);

        // Press whose apply cycle lands on the step terminal count.
        begin
            int guard = 0;
            @(negedge clk);
            while (((cyc + 1 + CNT_DEB + 4 - m_last) % STEP_BASE) != 0 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            check("align_found", guard < 50, 1);
        end
        key_pulse(10, 30);

        // Asynchronous reset while falling through duty=3 in mode 1.
        begin
            int guard = 0;
            while (!(bus.duty == 8'd3 && bus.dir == 1'b0) && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            check("reach_fall3", guard < 300, 1);
            check("pre_rst_mode", bus.mode, 1);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_duty", bus.duty, 0);
        check("arst_dir", bus.dir, 1);
        check("arst_mode", bus.mode, 0);
        check("arst_valid", bus.duty_valid, 0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Long hold: one press, nothing on release.
        key_pulse(200, 40);

        // Randomised glitches and presses.
        for (int i = 0; i < 8; i++) begin
            key_pulse($urandom_range(CNT_DEB - 1, 1), $urandom_range(10, CNT_DEB + 2));
            key_pulse($urandom_range(30, CNT_DEB), $urandom_range(50, CNT_DEB + 6));
        end

        begin
            int guard = 0;
            while (press_q.size() != 0 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            check("press_queue_drained", press_q.size(), 0);
        end
        repeat (30) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
